fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage: PC register, next-PC selection and the IF/ID pipeline register.
- Consumes the branch unit's redirect outputs (pc_sel, br_pc, halt) from EX.
- Drives the instruction-memory address and captures the returned word into IF/ID for decode.
- Owns the halted state of the core and a redirect statistics counter.

Parameters:
- PC_W, 9, width of the PC and instruction address in bytes.
- NOP_INST, 32'h0000_0013, word inserted into IF/ID on a bubble (addi x0,x0,0).
- CNT_W, 16, width of the redirect counter.

Ports:
- clk  in  1  core clock.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  hazard-unit stall request; hold PC and IF/ID.
- pc_sel  in  1  redirect request from the branch unit (taken branch, jump or halt).
- br_pc  in  32  redirect target; only bits [PC_W-1:0] are used.
- halt  in  1  halt request from the branch unit; valid only together with pc_sel.
- inst_rdata  in  32  instruction word from memory; combinational read of inst_addr, same cycle.
- inst_addr  out  PC_W  current PC, driven straight from the PC register.
- if_id_pc  out  PC_W  PC of the instruction held in IF/ID.
- if_id_inst  out  32  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  core is halted.
- misalign_err  out  1  sticky flag: a redirect target had br_pc[1:0] != 0.
- redirect_cnt  out  CNT_W  saturating count of accepted redirects.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: pc=0, if_id_pc=0, if_id_inst=NOP_INST, if_id_valid=0, halted=0, misalign_err=0, redirect_cnt=0. State is RUN.
- States: RUN and HALTED.
  - RUN goes to HALTED on pc_sel & halt.
  - HALTED is left only by reset.
- Per-cycle priority in RUN: reset > redirect (pc_sel) > stall > sequential.
- Redirect (pc_sel=1): this overrides stall.
  - pc <= {br_pc[PC_W-1:2], 2'b00}; the target is forced word-aligned.
  - IF/ID <= bubble (valid=0, inst=NOP_INST, pc unchanged).
  - redirect_cnt increments and saturates at all-ones.
  - If br_pc[1:0] != 0, misalign_err <= 1. It is sticky until reset.
  - br_pc bits above PC_W are ignored with no error.
- Halt (pc_sel & halt):
  - pc <= aligned br_pc, which is the halting instruction's PC.
  - IF/ID <= bubble, halted <= 1, and redirect_cnt increments.
  - halt without pc_sel is ignored.
- Stall (stall=1, pc_sel=0): pc, IF/ID and the counters all hold.
- Sequential (no stall, no redirect):
  - pc <= pc + 4, wrapping modulo 2^PC_W (so 0x1FC goes to 0x000 at PC_W=9).
  - IF/ID <= {pc, inst_rdata, valid=1}.
- HALTED:
  - pc holds at the halt PC; IF/ID holds the bubble.
  - All of stall, pc_sel, halt and br_pc are ignored; counters freeze.
- Latency:
  - The word fetched at inst_addr in cycle N appears on if_id_* in cycle N+1.
  - A redirect in cycle N fetches its target in cycle N+1, which appears in IF/ID in N+2.
  - The stage therefore inserts exactly one bubble per redirect.
  - Flushing ID/EX is outside this block.
- Reset mid-operation: reset wins in any state, including HALTED and during a stall. The next fetch is from address 0.
- inst_addr is purely the PC register, with no combinational path from pc_sel or br_pc. This avoids a timing loop through EX.

Decomposition:
- Shared package (fetch_pkg or the core's common package):
  - NOP_INST constant.
  - fetch_state_e enum {RUN, HALTED}.
  - if_id_t packed struct {pc, inst, valid}, which the decode stage also imports.
- One natural sub-module: sat_counter (parameter CNT_W; ports clk, reset, inc, count). It implements redirect_cnt.
- Next-PC mux and IF/ID register stay inline.

Test Plan:
- Reset, then 4 free-running cycles with memory returning 0xA0+addr -> inst_addr 0,4,8,C. if_id lags by one cycle: pc 0,4,8 with valid=1.
- Stall held 2 cycles at pc=8 -> inst_addr stays 8 and IF/ID holds pc=4. On release, pc=C next cycle.
- pc_sel=1, br_pc=0x40, with stall=1 in the same cycle -> next cycle pc=0x40, if_id_valid=0, inst=0x13, redirect_cnt=1. One cycle later if_id_pc=0x40, valid=1.
- pc_sel=1, br_pc=0x0000_0106 -> pc=0x104 and misalign_err=1. The flag persists after 10 further cycles.
- pc=0x1FC, no stall -> pc=0x000 next cycle with no error.
- pc_sel=1, halt=1, br_pc=0x24 -> halted=1 and pc=0x24. Subsequent pc_sel=1, br_pc=0x80 has no effect and the counter is frozen. Asserting reset -> halted=0, pc=0, redirect_cnt=0.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants.
// Decode imports if_id_t from here so both stages agree on the IF/ID layout.
package fetch_stage_pkg;

    localparam int          FETCH_PC_W     = 9;
    localparam logic [31:0] FETCH_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_PC_W-1:0] pc;
        logic [31:0]           inst;
        logic                  valid;
    } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Bundle of the fetch stage's handshake and bus signals.
// The slave modport is the fetch stage itself; the master side is the surrounding core.
interface fetch_stage_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic             stall;
    logic             pc_sel;
    logic [31:0]      br_pc;
    logic             halt;
    logic [31:0]      inst_rdata;
    logic [PC_W-1:0]  inst_addr;
    logic [PC_W-1:0]  if_id_pc;
    logic [31:0]      if_id_inst;
    logic             if_id_valid;
    logic             halted;
    logic             misalign_err;
    logic [CNT_W-1:0] redirect_cnt;

    modport master (
        output stall, pc_sel, br_pc, halt, inst_rdata,
        input  inst_addr, if_id_pc, if_id_inst, if_id_valid,
               halted, misalign_err, redirect_cnt
    );

    modport slave (
        input  stall, pc_sel, br_pc, halt, inst_rdata,
        output inst_addr, if_id_pc, if_id_inst, if_id_valid,
               halted, misalign_err, redirect_cnt
    );

endinterface

// File: rtl/fetch_stage_sat_counter.sv
// Saturating up-counter used for the redirect statistics.
// Once it reaches all-ones it stays there until reset.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;

    // Count accepted events, holding at all-ones instead of wrapping
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection and IF/ID register.
// inst_addr comes straight from the PC flop so EX redirects never form a
// combinational path to instruction memory.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter int          PC_W     = FETCH_PC_W,
    parameter logic [31:0] NOP_INST = FETCH_NOP_INST,
    parameter int          CNT_W    = 16
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    if_id_t          ifid_q, ifid_d;
    logic            misalign_q, misalign_d;
    logic            redirect_inc;
    logic [PC_W-1:0] redirect_target;

    // Upper target bits beyond the PC width are deliberately dropped
    logic unused_br_bits;
    assign unused_br_bits = ^bus.br_pc[31:PC_W];

    // Redirect targets are always forced onto a word boundary
    assign redirect_target = {bus.br_pc[PC_W-1:2], 2'b00};

    // Next-state selection: redirect beats stall, stall beats sequential fetch
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ifid_d       = ifid_q;
        misalign_d   = misalign_q;
        redirect_inc = 1'b0;
        if (state_q == RUN) begin
            if (bus.pc_sel) begin
                pc_d         = redirect_target;
                ifid_d.inst  = NOP_INST;
                ifid_d.valid = 1'b0;
                redirect_inc = 1'b1;
                if (bus.br_pc[1:0] != 2'b00) begin
                    misalign_d = 1'b1;
                end
                if (bus.halt) begin
                    state_d = HALTED;
                end
            end else if (!bus.stall) begin
                pc_d         = pc_q + PC_W'(4);
                ifid_d.pc    = pc_q;
                ifid_d.inst  = bus.inst_rdata;
                ifid_d.valid = 1'b1;
            end
        end
    end

    // State, PC, IF/ID and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= RUN;
            pc_q       <= '0;
            ifid_q     <= '{pc: '0, inst: NOP_INST, valid: 1'b0};
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ifid_q     <= ifid_d;
            misalign_q <= misalign_d;
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redirect_inc),
        .count (bus.redirect_cnt)
    );

    assign bus.inst_addr    = pc_q;
    assign bus.if_id_pc     = ifid_q.pc;
    assign bus.if_id_inst   = ifid_q.inst;
    assign bus.if_id_valid  = ifid_q.valid;
    assign bus.halted       = (state_q == HALTED);
    assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: a behavioural model queues the expected state for
// every driven cycle, and it is popped and compared one cycle later.
module tb_fetch_stage;
    import fetch_stage_pkg::*;

    localparam int PC_W    = 9;
    localparam int CNT_W   = 4;
    localparam logic [31:0] PC_MASK = (32'd1 << PC_W) - 32'd1;
    localparam logic [31:0] CNT_MAX = (32'd1 << CNT_W) - 32'd1;

    logic clk;
    logic reset;

    fetch_stage_if #(.PC_W(PC_W), .CNT_W(CNT_W)) fetchBus ();

    fetch_stage #(
        .PC_W     (PC_W),
        .NOP_INST (32'h0000_0013),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (fetchBus.slave)
    );

    // Instruction memory returns 0xA0 + address, combinationally
    assign fetchBus.inst_rdata = 32'h0000_00A0 + 32'(fetchBus.inst_addr);

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ifPc;
        logic [31:0] ifInst;
        logic        ifValid;
        logic        halted;
        logic        err;
        logic [31:0] cnt;
    } expT;

    expT sbQueue[$];
    int  checks   = 0;
    int  failures = 0;

    logic [31:0] mPc, mIfPc, mIfInst, mCnt;
    logic        mIfValid, mHalted, mErr;

    // Count one comparison and report it if it does not match
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance the reference model by one clock
    task automatic modelStep(input logic rst, input logic st, input logic ps,
                             input logic hl, input logic [31:0] bp);
        if (rst) begin
            mPc = 0; mIfPc = 0; mIfInst = 32'h13; mIfValid = 0;
            mHalted = 0; mErr = 0; mCnt = 0;
        end else if (!mHalted) begin
            if (ps) begin
                mPc      = bp & PC_MASK & 32'hFFFF_FFFC;
                mIfInst  = 32'h13;
                mIfValid = 0;
                if (bp[1:0] != 2'b00) mErr = 1;
                if (mCnt < CNT_MAX) mCnt = mCnt + 1;
                if (hl) mHalted = 1;
            end else if (!st) begin
                mIfPc    = mPc;
                mIfInst  = 32'hA0 + mPc;
                mIfValid = 1;
                mPc      = (mPc + 4) & PC_MASK;
            end
        end
    endtask

    // Drive one cycle of inputs, queue the expectation, then compare after the edge
    task automatic applyStimulus(input logic rst, input logic st, input logic ps,
                                 input logic hl, input logic [31:0] bp, input string tag);
        expT e;
        reset           = rst;
        fetchBus.stall  = st;
        fetchBus.pc_sel = ps;
        fetchBus.halt   = hl;
        fetchBus.br_pc  = bp;
        modelStep(rst, st, ps, hl, bp);
        sbQueue.push_back('{mPc, mIfPc, mIfInst, mIfValid, mHalted, mErr, mCnt});
        @(posedge clk);
        #1;
        e = sbQueue.pop_front();
        checkOutput({tag, ".addr"},  32'(fetchBus.inst_addr),    e.pc);
        checkOutput({tag, ".ifpc"},  32'(fetchBus.if_id_pc),     e.ifPc);
        checkOutput({tag, ".inst"},  fetchBus.if_id_inst,        e.ifInst);
        checkOutput({tag, ".valid"}, 32'(fetchBus.if_id_valid),  32'(e.ifValid));
        checkOutput({tag, ".halt"},  32'(fetchBus.halted),       32'(e.halted));
        checkOutput({tag, ".err"},   32'(fetchBus.misalign_err), 32'(e.err));
        checkOutput({tag, ".cnt"},   32'(fetchBus.redirect_cnt), e.cnt);
    endtask

    // Test sequence
    initial begin
        reset = 1'b1;
        fetchBus.stall = 0; fetchBus.pc_sel = 0; fetchBus.halt = 0; fetchBus.br_pc = 0;

        applyStimulus(1, 0, 0, 0, 32'h0, "reset0");
        applyStimulus(1, 0, 0, 0, 32'h0, "reset1");
        checkOutput("rst_inst_nop", fetchBus.if_id_inst, 32'h13);

        applyStimulus(0, 0, 0, 0, 32'h0, "free1");
        applyStimulus(0, 0, 0, 0, 32'h0, "free2");
        checkOutput("free_addr8", 32'(fetchBus.inst_addr), 32'h8);
        checkOutput("free_ifpc4", 32'(fetchBus.if_id_pc), 32'h4);

        applyStimulus(0, 1, 0, 0, 32'h0, "stall1");
        applyStimulus(0, 1, 0, 0, 32'h0, "stall2");
        checkOutput("stall_addr", 32'(fetchBus.inst_addr), 32'h8);
        checkOutput("stall_ifpc", 32'(fetchBus.if_id_pc), 32'h4);
        applyStimulus(0, 0, 0, 0, 32'h0, "release");
        checkOutput("release_addr", 32'(fetchBus.inst_addr), 32'hC);
        checkOutput("release_inst", fetchBus.if_id_inst, 32'hA8);

        applyStimulus(0, 1, 1, 0, 32'h40, "redir_stall");
        checkOutput("redir_addr", 32'(fetchBus.inst_addr), 32'h40);
        checkOutput("redir_bubble", 32'(fetchBus.if_id_valid), 32'h0);
        checkOutput("redir_cnt", 32'(fetchBus.redirect_cnt), 32'h1);
        applyStimulus(0, 0, 0, 0, 32'h0, "after_redir");
        checkOutput("target_ifpc", 32'(fetchBus.if_id_pc), 32'h40);
        checkOutput("target_inst", fetchBus.if_id_inst, 32'hE0);

        applyStimulus(0, 0, 1, 0, 32'hABCD_E020, "high_bits");
        checkOutput("high_bits_addr", 32'(fetchBus.inst_addr), 32'h20);
        checkOutput("high_bits_noerr", 32'(fetchBus.misalign_err), 32'h0);

        applyStimulus(0, 0, 0, 1, 32'h80, "halt_no_sel");
        checkOutput("halt_no_sel", 32'(fetchBus.halted), 32'h0);

        applyStimulus(0, 0, 1, 0, 32'h106, "misalign");
        checkOutput("misalign_addr", 32'(fetchBus.inst_addr), 32'h104);
        checkOutput("misalign_flag", 32'(fetchBus.misalign_err), 32'h1);
        for (int i = 0; i < 10; i++) applyStimulus(0, 0, 0, 0, 32'h0, "sticky");
        checkOutput("misalign_sticky", 32'(fetchBus.misalign_err), 32'h1);

        applyStimulus(0, 0, 1, 0, 32'h1FC, "to_top");
        applyStimulus(0, 0, 0, 0, 32'h0, "wrap");
        checkOutput("wrap_addr", 32'(fetchBus.inst_addr), 32'h0);
        checkOutput("wrap_ifpc", 32'(fetchBus.if_id_pc), 32'h1FC);

        applyStimulus(0, 0, 1, 1, 32'h24, "halt");
        checkOutput("halt_flag", 32'(fetchBus.halted), 32'h1);
        checkOutput("halt_addr", 32'(fetchBus.inst_addr), 32'h24);
        applyStimulus(0, 0, 1, 0, 32'h80, "halted_sel");
        applyStimulus(0, 1, 1, 1, 32'h80, "halted_mix");
        applyStimulus(0, 0, 0, 0, 32'h0, "halted_idle");
        checkOutput("halted_addr", 32'(fetchBus.inst_addr), 32'h24);
        checkOutput("halted_cnt", 32'(fetchBus.redirect_cnt), 32'h5);

        applyStimulus(1, 1, 1, 0, 32'h80, "reset_halted");
        checkOutput("reset_halted_flag", 32'(fetchBus.halted), 32'h0);
        checkOutput("reset_halted_cnt", 32'(fetchBus.redirect_cnt), 32'h0);

        for (int i = 0; i < 20; i++) applyStimulus(0, 0, 1, 0, 32'(i * 8), "sat");
        checkOutput("sat_cnt", 32'(fetchBus.redirect_cnt), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
